rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and scheduler for the 32×32 general register file (GRF) in the pipelined MIPS core. The GRF has a single write port. This block shares that port between two writers:

- the main pipeline W stage, which has priority;
- an auxiliary long-latency writer, such as a multi-cycle unit returning a GPR result.

Auxiliary writes wait in a small in-order buffer. The block drives the GRF write port directly, stalls the pipeline when the auxiliary writer would otherwise starve, and reports pending-register hits to decode for hazard stalls.

## Interface
Parameters:
- AUX_DEPTH, 2, auxiliary buffer entries (≥1).
- STARVE_MAX, 4, cycles the buffer head may be denied before the pipeline is stalled (≥1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  reset, asynchronous, active-low.
- pipe_we  in  1  W-stage write request.
- pipe_a3  in  5  W-stage destination register.
- pipe_wd  in  32  W-stage write data.
- pipe_pc4  in  32  W-stage PC+4, passed through for the write trace.
- pipe_stall  out  1  W stage must hold its request; the write is not performed this cycle.
- aux_valid  in  1  auxiliary write offered.
- aux_ready  out  1  buffer can accept an auxiliary write this cycle.
- aux_a3  in  5  auxiliary destination register.
- aux_wd  in  32  auxiliary write data.
- aux_pc4  in  32  auxiliary PC+4.
- q_a1, q_a2  in  5  decode source registers.
- q_hit1, q_hit2  out  1  the source register has a live pending write in the buffer.
- rf_we, rf_a3, rf_wd, rf_pc4  out  1/5/32/32  GRF write port (RegWrite, A3, WD, pc4_W).

## Operation
Buffer:
- FIFO of AUX_DEPTH entries. Each entry holds a3, wd, pc4 and a live bit.
- aux_ready = !full, computed from registered state only; it does not depend on aux_valid.
- Handshake: an entry is enqueued on a posedge where aux_valid && aux_ready.
- An aux write with aux_a3==0 is accepted and discarded; it is never enqueued.

Grant (combinational, every cycle):
- pipe_req = pipe_we && pipe_a3!=0.
- force = nonempty && starve_cnt==STARVE_MAX.
- If force: grant the buffer head and assert pipe_stall.
- Else if pipe_req: grant pipe and drive rf_* from pipe_*.
- Else if nonempty: grant the head. A live head drives rf_we=1 with its fields. A dead head drives rf_we=0 and is popped silently.
- Else rf_we=0.
- pipe_stall is only ever asserted together with force.

Starvation counter (registered, 0..STARVE_MAX):
- Cleared when the buffer is empty or the head is popped.
- Otherwise incremented when the head is denied.

Ordering and supersede:
- Buffered aux writes are older than any pipe write presented afterwards.
- On a posedge where the pipe write is performed to register X, every live buffer entry with a3==X is marked dead.
- An entry enqueued on that same edge is not affected.

Hazard query:
- q_hitN = 1 iff some live entry has a3==q_aN and q_aN!=0.
- Purely combinational.

Simultaneous events:
- Enqueue and pop on the same edge are both performed when not full.
- When full, aux_ready=0 even if a pop happens that cycle.

## Timing
- Pipe write latency is 0: rf_* follow pipe_* combinationally and the GRF writes on the same posedge.
- Aux write latency from acceptance is at least 1 cycle. It is at most (AUX_DEPTH−1+1)·(STARVE_MAX+1) cycles.
- Reset (clr=0), asynchronous:
  - buffer emptied and all live bits cleared;
  - starve_cnt=0;
  - rf_we=0, pipe_stall=0, q_hit1=q_hit2=0;
  - aux_ready=1 once clr deasserts.
- Reset mid-operation discards all buffered writes; none reach the GRF.
- A forced head write and a stalled pipe write never occur on the same edge.

## Test plan
- Reset, then pipe_we=1, a3=5, wd=0x1234, no aux → rf_we=1, rf_a3=5 the same cycle; pipe_stall=0; aux_ready=1.
- Pipe idle, aux writes a3=8 wd=0xA then a3=9 wd=0xB → GRF written $8 then $9 on the next two edges, in order. q_hit1 for q_a1=8 is 1 until $8 is written.
- Pipe requests every cycle, one aux entry held → head denied 4 cycles, then on cycle 5 pipe_stall=1 and rf_a3 is the aux register. The pipe write completes the following cycle.
- Buffer holds a3=7 wd=0x1; pipe writes a3=7 wd=0x2 → entry dies and is popped without a write. $7 ends as 0x2; q_hit for 7 drops to 0.
- Fill both entries → aux_ready=0. A third aux_valid is not accepted. aux_a3=0 offered → accepted, buffer count unchanged, no GRF write.
- clr pulsed low mid-cycle with 2 entries buffered → outputs clear immediately; no buffered write ever appears on rf_we.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
// Bundles the signals around the GRF write-port arbiter.
//   pipe_*  : W-stage write request (we, a3, wd, pc4) and its stall back-pressure
//   aux_*   : auxiliary long-latency writer with valid/ready handshake
//   q_*     : decode hazard query (two source registers, two hit flags)
//   rf_*    : the single GRF write port (RegWrite, A3, WD, pc4_W)
// master : the surrounding core (drives requests, observes grants)
// slave  : the arbiter itself
interface rf_wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc4;
    logic        pipe_stall;

    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_a3;
    logic [31:0] aux_wd;
    logic [31:0] aux_pc4;

    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_hit1;
    logic        q_hit2;

    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc4;

    modport master (
        output pipe_we, pipe_a3, pipe_wd, pipe_pc4,
        output aux_valid, aux_a3, aux_wd, aux_pc4,
        output q_a1, q_a2,
        input  pipe_stall, aux_ready, q_hit1, q_hit2,
        input  rf_we, rf_a3, rf_wd, rf_pc4
    );

    modport slave (
        input  pipe_we, pipe_a3, pipe_wd, pipe_pc4,
        input  aux_valid, aux_a3, aux_wd, aux_pc4,
        input  q_a1, q_a2,
        output pipe_stall, aux_ready, q_hit1, q_hit2,
        output rf_we, rf_a3, rf_wd, rf_pc4
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single GRF write port between the W stage (priority) and an
// auxiliary long-latency writer whose results wait in a small in-order buffer.
// Ports:
//   clk : system clock, all state on posedge
//   clr : asynchronous active-low reset
//   bus : rf_wb_arbiter_if.slave (pipe / aux / hazard query / GRF write port)
// Parameters:
//   AUX_DEPTH  : auxiliary buffer entries (>=1)
//   STARVE_MAX : cycles the buffer head may be denied before the W stage stalls
module rf_wb_arbiter #(
    parameter int AUX_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input logic            clk,
    input logic            clr,
    rf_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
    localparam int CNT_W = $clog2(AUX_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(AUX_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(AUX_DEPTH);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

    // Circular pointer advance with wrap at the last slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [4:0]       a3_q   [AUX_DEPTH];
    logic [31:0]      wd_q   [AUX_DEPTH];
    logic [31:0]      pc4_q  [AUX_DEPTH];
    logic             live_q [AUX_DEPTH];
    logic [4:0]       a3_d   [AUX_DEPTH];
    logic [31:0]      wd_d   [AUX_DEPTH];
    logic [31:0]      pc4_d  [AUX_DEPTH];
    logic             live_d [AUX_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STV_W-1:0] starve_q, starve_d;

    logic        full_s, nonempty_s, pipe_req_s, force_s, head_live_s;
    logic        push_s, pop_s, pipe_wr_s;
    logic        rf_we_s, stall_s, hit1_s, hit2_s;
    logic [4:0]  rf_a3_s;
    logic [31:0] rf_wd_s, rf_pc4_s;

    assign full_s      = (cnt_q == DEPTH_CNT);
    assign nonempty_s  = (cnt_q != {CNT_W{1'b0}});
    assign pipe_req_s  = bus.pipe_we && (bus.pipe_a3 != 5'd0);
    assign force_s     = nonempty_s && (starve_q == STARVE_LIM);
    assign head_live_s = live_q[rd_ptr_q];
    // Writes to $0 complete the handshake but are dropped here.
    assign push_s      = bus.aux_valid && !full_s && (bus.aux_a3 != 5'd0);

    // Write-port grant: forced head, then pipe, then opportunistic head drain.
    always_comb begin
        rf_we_s   = 1'b0;
        rf_a3_s   = 5'd0;
        rf_wd_s   = 32'd0;
        rf_pc4_s  = 32'd0;
        stall_s   = 1'b0;
        pop_s     = 1'b0;
        pipe_wr_s = 1'b0;
        if (force_s) begin
            stall_s  = 1'b1;
            pop_s    = 1'b1;
            rf_we_s  = head_live_s;
            rf_a3_s  = a3_q[rd_ptr_q];
            rf_wd_s  = wd_q[rd_ptr_q];
            rf_pc4_s = pc4_q[rd_ptr_q];
        end else if (pipe_req_s) begin
            pipe_wr_s = 1'b1;
            rf_we_s   = 1'b1;
            rf_a3_s   = bus.pipe_a3;
            rf_wd_s   = bus.pipe_wd;
            rf_pc4_s  = bus.pipe_pc4;
        end else if (nonempty_s) begin
            // A dead head is popped with the write enable low.
            pop_s    = 1'b1;
            rf_we_s  = head_live_s;
            rf_a3_s  = a3_q[rd_ptr_q];
            rf_wd_s  = wd_q[rd_ptr_q];
            rf_pc4_s = pc4_q[rd_ptr_q];
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Buffer next state: supersede, pop, push, occupancy and starvation.
    always_comb begin
        a3_d     = a3_q;
        wd_d     = wd_q;
        pc4_d    = pc4_q;
        live_d   = live_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        // A performed pipe write makes older buffered writes to the same register obsolete.
        for (int i = 0; i < AUX_DEPTH; i++) begin
            if (pipe_wr_s && live_q[i] && (a3_q[i] == bus.pipe_a3)) begin
                live_d[i] = 1'b0;
            end else begin
                live_d[i] = live_q[i];
            end
        end
        if (pop_s) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Push last so an entry written on a supersede edge stays live.
        if (push_s) begin
            a3_d[wr_ptr_q]   = bus.aux_a3;
            wd_d[wr_ptr_q]   = bus.aux_wd;
            pc4_d[wr_ptr_q]  = bus.aux_pc4;
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (push_s && !pop_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (!nonempty_s || pop_s) begin
            starve_d = {STV_W{1'b0}};
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + STV_W'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Buffer and counter registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < AUX_DEPTH; i++) begin
                a3_q[i]   <= 5'd0;
                wd_q[i]   <= 32'd0;
                pc4_q[i]  <= 32'd0;
                live_q[i] <= 1'b0;
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            starve_q <= {STV_W{1'b0}};
        end else begin
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            pc4_q    <= pc4_d;
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Decode hazard query against live buffered writes; $0 never hits.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int i = 0; i < AUX_DEPTH; i++) begin
            if (live_q[i] && (a3_q[i] == bus.q_a1)) begin
                hit1_s = 1'b1;
            end else begin
                hit1_s = hit1_s;
            end
            if (live_q[i] && (a3_q[i] == bus.q_a2)) begin
                hit2_s = 1'b1;
            end else begin
                hit2_s = hit2_s;
            end
        end
    end

    // Outputs are held quiet while clr is asserted, even if the pipe is requesting.
    assign bus.rf_we      = clr && rf_we_s;
    assign bus.rf_a3      = rf_a3_s;
    assign bus.rf_wd      = rf_wd_s;
    assign bus.rf_pc4     = rf_pc4_s;
    assign bus.pipe_stall = clr && stall_s;
    assign bus.aux_ready  = !full_s;
    assign bus.q_hit1     = clr && hit1_s && (bus.q_a1 != 5'd0);
    assign bus.q_hit2     = clr && hit2_s && (bus.q_a2 != 5'd0);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    localparam int AUX_DEPTH  = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc4;
        bit          live;
    } ent_t;

    logic clk;
    logic clr;
    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.AUX_DEPTH(AUX_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: pending aux writes in program order, head denial count, and GRF contents.
    ent_t        mq[$];
    int          denied_m = 0;
    logic [31:0] grf_m   [32];
    logic [31:0] grf_dut [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GRF as written by the DUT's write port.
    always @(posedge clk) begin
        if (clr && bus.rf_we && bus.rf_a3 != 5'd0) grf_dut[bus.rf_a3] <= bus.rf_wd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic cyc(input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                       input logic av, input logic [4:0] aa3, input logic [31:0] awd,
                       input logic [4:0] q1, input logic [4:0] q2);
        bit ready_e, preq, frc, we_e, stall_e, h1, h2, pop, push;
        logic [4:0]  a3_e;
        logic [31:0] wd_e, pc4_e, ppc, apc;
        @(negedge clk);
        ppc = $urandom; apc = $urandom;
        bus.pipe_we = pwe; bus.pipe_a3 = pa3; bus.pipe_wd = pwd; bus.pipe_pc4 = ppc;
        bus.aux_valid = av; bus.aux_a3 = aa3; bus.aux_wd = awd; bus.aux_pc4 = apc;
        bus.q_a1 = q1; bus.q_a2 = q2;
        #1;
        ready_e = mq.size() < AUX_DEPTH;
        preq    = pwe && pa3 != 5'd0;
        frc     = mq.size() > 0 && denied_m == STARVE_MAX;
        stall_e = frc;
        pop = 1'b0; we_e = 1'b0; a3_e = 5'd0; wd_e = 32'd0; pc4_e = 32'd0;
        if (frc || (!preq && mq.size() > 0)) begin
            pop = 1'b1; we_e = mq[0].live; a3_e = mq[0].a3; wd_e = mq[0].wd; pc4_e = mq[0].pc4;
        end else if (preq) begin
            we_e = 1'b1; a3_e = pa3; wd_e = pwd; pc4_e = ppc;
        end
        h1 = 1'b0; h2 = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].a3 == q1 && q1 != 5'd0) h1 = 1'b1;
            if (mq[i].live && mq[i].a3 == q2 && q2 != 5'd0) h2 = 1'b1;
        end
        chk("aux_ready",  {31'd0, bus.aux_ready},  {31'd0, ready_e});
        chk("pipe_stall", {31'd0, bus.pipe_stall}, {31'd0, stall_e});
        chk("rf_we",      {31'd0, bus.rf_we},      {31'd0, we_e});
        chk("q_hit1",     {31'd0, bus.q_hit1},     {31'd0, h1});
        chk("q_hit2",     {31'd0, bus.q_hit2},     {31'd0, h2});
        if (we_e) begin
            chk("rf_a3",  {27'd0, bus.rf_a3}, {27'd0, a3_e});
            chk("rf_wd",  bus.rf_wd,  wd_e);
            chk("rf_pc4", bus.rf_pc4, pc4_e);
            grf_m[a3_e] = wd_e;
        end
        // Model advance: a performed pipe write kills older pending writes to its register.
        if (!frc && preq) begin
            foreach (mq[i]) if (mq[i].a3 == pa3) mq[i].live = 1'b0;
        end
        push = av && ready_e && aa3 != 5'd0;
        if (mq.size() == 0 || pop) denied_m = 0;
        else denied_m = denied_m + 1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{a3: aa3, wd: awd, pc4: apc, live: 1'b1});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
    task automatic pulse_reset(input logic [4:0] qa);
        @(negedge clk);
        bus.pipe_we = 1'b0; bus.aux_valid = 1'b0; bus.q_a1 = qa; bus.q_a2 = qa;
        #2;
        clr = 1'b0;
        #1;
        chk("rst_rf_we",  {31'd0, bus.rf_we},      32'd0);
        chk("rst_stall",  {31'd0, bus.pipe_stall}, 32'd0);
        chk("rst_hit1",   {31'd0, bus.q_hit1},     32'd0);
        chk("rst_hit2",   {31'd0, bus.q_hit2},     32'd0);
        mq.delete();
        denied_m = 0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin grf_m[r] = 32'd0; grf_dut[r] = 32'd0; end
        clr = 1'b0;
        bus.pipe_we = 1'b0; bus.pipe_a3 = 5'd0; bus.pipe_wd = 32'd0; bus.pipe_pc4 = 32'd0;
        bus.aux_valid = 1'b0; bus.aux_a3 = 5'd0; bus.aux_wd = 32'd0; bus.aux_pc4 = 32'd0;
        bus.q_a1 = 5'd0; bus.q_a2 = 5'd0;
        #3;
        chk("init_rf_we", {31'd0, bus.rf_we},      32'd0);
        chk("init_stall", {31'd0, bus.pipe_stall}, 32'd0);
        chk("init_hit1",  {31'd0, bus.q_hit1},     32'd0);
        @(negedge clk);
        clr = 1'b1;

        // Pipe write passes straight through.
        cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("pipe_rf_we", {31'd0, bus.rf_we}, 32'd1);
        chk("pipe_rf_a3", {27'd0, bus.rf_a3}, 32'd5);
        chk("pipe_ready", {31'd0, bus.aux_ready}, 32'd1);

        // Two aux writes drain in order while the pipe is idle.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hA, 5'd8, 5'd9);
        chk("aux_first_idle", {31'd0, bus.rf_we}, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hB, 5'd8, 5'd9);
        chk("aux_w8_a3", {27'd0, bus.rf_a3}, 32'd8);
        chk("aux_hit8",  {31'd0, bus.q_hit1}, 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd9);
        chk("aux_w9_a3", {27'd0, bus.rf_a3}, 32'd9);
        chk("aux_hit8_gone", {31'd0, bus.q_hit1}, 32'd0);

        // Starvation: head denied four cycles, forced on the fifth.
        cyc(1'b1, 5'd10, 32'h100, 1'b1, 5'd3, 32'h33, 5'd3, 5'd0);
        for (int k = 0; k < STARVE_MAX; k++) begin
            cyc(1'b1, 5'd10, 32'h100, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
            chk("starve_nostall", {31'd0, bus.pipe_stall}, 32'd0);
        end
        cyc(1'b1, 5'd10, 32'h100, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        chk("force_stall", {31'd0, bus.pipe_stall}, 32'd1);
        chk("force_a3",    {27'd0, bus.rf_a3},      32'd3);
        cyc(1'b1, 5'd10, 32'h100, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        chk("after_force_a3", {27'd0, bus.rf_a3}, 32'd10);

        // Supersede: pipe write to $7 kills the buffered $7 write.
        cyc(1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'h1, 5'd7, 5'd0);
        cyc(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        chk("sup_hit7_live", {31'd0, bus.q_hit1}, 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        chk("sup_dead_nowr", {31'd0, bus.rf_we},  32'd0);
        chk("sup_hit7_gone", {31'd0, bus.q_hit1}, 32'd0);
        idle(1);
        chk("sup_reg7", grf_dut[7], 32'h2);

        // Full buffer refuses; a $0 aux write is accepted and dropped.
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'hB11, 5'd11, 5'd12);
        cyc(1'b1, 5'd1, 32'h12, 1'b1, 5'd12, 32'hB12, 5'd11, 5'd12);
        cyc(1'b1, 5'd1, 32'h13, 1'b1, 5'd13, 32'hB13, 5'd11, 5'd13);
        chk("full_ready", {31'd0, bus.aux_ready}, 32'd0);
        chk("full_hit13", {31'd0, bus.q_hit2},    32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hB13, 5'd11, 5'd13);
        cyc(1'b1, 5'd1, 32'h14, 1'b1, 5'd0, 32'hDEAD, 5'd12, 5'd0);
        cyc(1'b1, 5'd1, 32'h15, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        chk("zero_ready", {31'd0, bus.aux_ready}, 32'd1);
        idle(3);

        // Reset mid-operation discards two buffered writes.
        cyc(1'b1, 5'd2, 32'h21, 1'b1, 5'd14, 32'hC14, 5'd14, 5'd15);
        cyc(1'b1, 5'd2, 32'h22, 1'b1, 5'd15, 32'hC15, 5'd14, 5'd15);
        pulse_reset(5'd14);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd14, 5'd15);
            chk("post_rst_nowr", {31'd0, bus.rf_we}, 32'd0);
        end

        // Random traffic on a small register range to exercise hits and supersede.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(12);
        for (int r = 1; r < 32; r++) chk($sformatf("grf_%0d", r), grf_dut[r], grf_m[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
